gigatron_ram_arbiter: RTL

//  Shares one synchronous single-port RAM between the Gigatron CPU core and a host port (loader/debugger).

---
 rtl/gigatron_ram_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/gigatron_ram_arbiter.sv
// gigatron_ram_arbiter
//   Time-slices one synchronous single-port RAM between the Gigatron CPU
//   core and a host port (loader/debugger). The system clock is divided into
//   frames of DIV cycles. Each frame has a fixed slot for the CPU write, the
//   CPU read and one host access. The core's ready input gets exactly one
//   pulse per frame.
//
//   Frame layout (slot = s):
//     0        buffered CPU write (if one is pending)
//     1        CPU read of the address latched at the last ready pulse
//     2        CPU read data captured; host request sampled and issued
//     3        host ack for the transaction issued in slot 2
//     4..DIV-1 idle
//     DIV-1    also the ready cycle (o_cpu_ready) when i_cpu_run=1
//
// Ports
//   i_clock, i_reset         clock, synchronous active-high reset
//   i_cpu_run                0 holds the core (no ready pulses)
//   i_cpu_raddr/waddr/wdata  core RAM read address, write address and data
//   i_cpu_we                 core write enable (already gated by ready)
//   o_cpu_rdata, o_cpu_ready read data and ready pulse to the core
//   i_host_req/we/addr/wdata host request (level, held until ack)
//   o_host_ack, o_host_rdata one-cycle ack and host read data
//   o_ram_addr/wdata/we      RAM request
//   i_ram_rdata              RAM data, one cycle after its address
module gigatron_ram_arbiter #(
  parameter int DIV = 4
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_cpu_run,
  input  logic [15:0] i_cpu_raddr,
  input  logic [15:0] i_cpu_waddr,
  input  logic [7:0]  i_cpu_wdata,
  input  logic        i_cpu_we,
  output logic [7:0]  o_cpu_rdata,
  output logic        o_cpu_ready,
  input  logic        i_host_req,
  input  logic        i_host_we,
  input  logic [15:0] i_host_addr,
  input  logic [7:0]  i_host_wdata,
  output logic        o_host_ack,
  output logic [7:0]  o_host_rdata,
  output logic [15:0] o_ram_addr,
  output logic [7:0]  o_ram_wdata,
  output logic        o_ram_we,
  input  logic [7:0]  i_ram_rdata
);

  localparam int SW = $clog2(DIV);
  localparam logic [SW-1:0] LAST = SW'(DIV - 1);
  localparam logic [SW-1:0] S0   = SW'(0);
  localparam logic [SW-1:0] S1   = SW'(1);
  localparam logic [SW-1:0] S2   = SW'(2);
  localparam logic [SW-1:0] S3   = SW'(3);

  logic [SW-1:0] s;
  logic          wpend;
  logic          hpend;
  logic          hwe;
  logic [15:0]   raddr_q;
  logic [15:0]   waddr_q;
  logic [7:0]    wdata_q;
  logic [7:0]    cpu_rdata_q;
  logic [7:0]    host_rdata_q;

  // Ready is decoded from the registered slot counter; reset masks it so the
  // core never advances while the arbiter is being cleared.
  assign o_cpu_ready = i_cpu_run & (s == LAST) & ~i_reset;
  assign o_cpu_rdata = cpu_rdata_q;

  // The ack is the pending flag itself, so it is high for exactly the slot-3
  // cycle that follows the slot-2 sample.
  assign o_host_ack  = hpend & ~i_reset;

  // The RAM returns the host read data during slot 3 (address issued in
  // slot 2), so the ack cycle forwards it straight through; the register
  // keeps it valid after the ack. Host writes leave the old value visible.
  assign o_host_rdata = (o_host_ack & ~hwe) ? i_ram_rdata : host_rdata_q;

  // RAM request is a pure decode of the slot; everything is forced to zero
  // outside the three active slots and while in reset.
  always_comb begin
    o_ram_we    = 1'b0;
    o_ram_addr  = 16'h0000;
    o_ram_wdata = 8'h00;
    if (!i_reset) begin
      if (s == S0) begin
        if (wpend) begin
          o_ram_we    = 1'b1;
          o_ram_addr  = waddr_q;
          o_ram_wdata = wdata_q;
        end
      end else if (s == S1) begin
        o_ram_addr = raddr_q;
      end else if (s == S2) begin
        if (i_host_req) begin
          o_ram_we    = i_host_we;
          o_ram_addr  = i_host_addr;
          o_ram_wdata = i_host_wdata;
        end
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      s            <= '0;
      wpend        <= 1'b0;
      hpend        <= 1'b0;
      hwe          <= 1'b0;
      raddr_q      <= 16'h0000;
      waddr_q      <= 16'h0000;
      wdata_q      <= 8'h00;
      cpu_rdata_q  <= 8'h00;
      host_rdata_q <= 8'h00;
    end else begin
      s <= (s == LAST) ? '0 : s + 1'b1;

      // Slot 0 retires the buffered write. Ready only occurs in the last
      // slot, so the set below can never collide with this clear.
      if (s == S0)
        wpend <= 1'b0;

      if (o_cpu_ready) begin
        raddr_q <= i_cpu_raddr;
        if (i_cpu_we) begin
          waddr_q <= i_cpu_waddr;
          wdata_q <= i_cpu_wdata;
          wpend   <= 1'b1;
        end
      end

      if (s == S2) begin
        cpu_rdata_q <= i_ram_rdata;
        if (i_host_req) begin
          hpend <= 1'b1;
          hwe   <= i_host_we;
        end
      end

      if (s == S3 && hpend) begin
        hpend <= 1'b0;
        if (!hwe)
          host_rdata_q <= i_ram_rdata;
      end
    end
  end

endmodule
